// File: rtl/sorted_metric_table.sv
// Sorted multi-metric entry table: one ascending list per metric, handshaked
// insert/delete/clear, and a back-pressured filtered/limited streaming read.
module sorted_metric_table #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned DEPTH_LOG   = 8,
  parameter int unsigned NUM_METRICS = 8,
  parameter int unsigned METRIC_LOG  = 3,
  parameter int unsigned VAL_W       = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [2:0]                   req_op,
  input  logic [DEPTH_LOG-1:0]         req_id,
  input  logic [NUM_METRICS*VAL_W-1:0] req_metrics,
  input  logic [DEPTH-1:0]             req_mask,
  input  logic [METRIC_LOG-1:0]        req_sel,
  input  logic [DEPTH_LOG:0]           req_limit,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [VAL_W-1:0]             out_val,
  output logic [DEPTH_LOG-1:0]         out_id,
  output logic                         resp_valid,
  output logic [1:0]                   resp_status,
  output logic [DEPTH_LOG:0]           resp_count,
  output logic [DEPTH_LOG:0]           count
);

  localparam int unsigned CW = DEPTH_LOG + 1;

  localparam logic [2:0] OP_INSERT = 3'd0;
  localparam logic [2:0] OP_DELETE = 3'd1;
  localparam logic [2:0] OP_READ_F = 3'd2;
  localparam logic [2:0] OP_READ_A = 3'd3;
  localparam logic [2:0] OP_CLEAR  = 3'd4;

  localparam logic [1:0] ST_OK     = 2'd0;
  localparam logic [1:0] ST_FULL   = 2'd1;
  localparam logic [1:0] ST_EXIST  = 2'd2;
  localparam logic [1:0] ST_ABSENT = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_CMP, S_COMMIT, S_SCAN, S_DONE} state_t;

  state_t                       state_q, state_d;
  logic                         req_ready_q, req_ready_d;
  logic [2:0]                   op_q, op_d;
  logic [DEPTH_LOG-1:0]         rid_q, rid_d;
  logic [NUM_METRICS*VAL_W-1:0] rmet_q, rmet_d;
  logic [DEPTH-1:0]             mask_q, mask_d;
  logic [METRIC_LOG-1:0]        sel_q, sel_d;
  logic [CW-1:0]                limit_q, limit_d;
  logic [CW-1:0]                pos_q [NUM_METRICS];
  logic [CW-1:0]                pos_d [NUM_METRICS];
  logic [1:0]                   err_q, err_d;
  logic [VAL_W-1:0]             val_q [NUM_METRICS][DEPTH];
  logic [VAL_W-1:0]             val_d [NUM_METRICS][DEPTH];
  logic [DEPTH_LOG-1:0]         id_q  [NUM_METRICS][DEPTH];
  logic [DEPTH_LOG-1:0]         id_d  [NUM_METRICS][DEPTH];
  logic [CW-1:0]                count_q, count_d;
  logic [CW-1:0]                idx_q, idx_d;
  logic [CW-1:0]                emitted_q, emitted_d;
  logic                         out_valid_q, out_valid_d;
  logic [VAL_W-1:0]             out_val_q, out_val_d;
  logic [DEPTH_LOG-1:0]         out_id_q, out_id_d;
  logic                         resp_valid_q, resp_valid_d;
  logic [1:0]                   resp_status_q, resp_status_d;
  logic [CW-1:0]                resp_count_q, resp_count_d;

  logic [CW-1:0]                ins_pos_c [NUM_METRICS];
  logic [CW-1:0]                hit_pos_c [NUM_METRICS];
  logic                         hit_c     [NUM_METRICS];

  // Per-list insertion position (count of entries <= new value) and first id match
  always_comb begin
    for (int m = 0; m < NUM_METRICS; m++) begin
      ins_pos_c[m] = '0;
      hit_pos_c[m] = '0;
      hit_c[m]     = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) < count_q) begin
          if (val_q[METRIC_LOG'(m)][DEPTH_LOG'(i)] <= rmet_q[m*VAL_W +: VAL_W]) begin
            ins_pos_c[m] = ins_pos_c[m] + CW'(1);
          end
          if (!hit_c[m] && (id_q[METRIC_LOG'(m)][DEPTH_LOG'(i)] == rid_q)) begin
            hit_c[m]     = 1'b1;
            hit_pos_c[m] = CW'(i);
          end
        end
      end
    end
  end

  // Next-state, datapath updates and registered outputs
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    rid_d         = rid_q;
    rmet_d        = rmet_q;
    mask_d        = mask_q;
    sel_d         = sel_q;
    limit_d       = limit_q;
    pos_d         = pos_q;
    err_d         = err_q;
    val_d         = val_q;
    id_d          = id_q;
    count_d       = count_q;
    idx_d         = idx_q;
    emitted_d     = emitted_q;
    out_valid_d   = out_valid_q;
    out_val_d     = out_val_q;
    out_id_d      = out_id_q;
    resp_valid_d  = 1'b0;
    resp_status_d = resp_status_q;
    resp_count_d  = resp_count_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          op_d      = req_op;
          rid_d     = req_id;
          rmet_d    = req_metrics;
          mask_d    = req_mask;
          sel_d     = req_sel;
          limit_d   = req_limit;
          idx_d     = '0;
          emitted_d = '0;
          if ((req_op == OP_READ_F) || (req_op == OP_READ_A)) begin
            if (32'(req_sel) >= NUM_METRICS) begin
              state_d       = S_DONE;
              resp_valid_d  = 1'b1;
              resp_status_d = ST_ABSENT;
              resp_count_d  = '0;
            end else if (count_q == '0) begin
              state_d       = S_DONE;
              resp_valid_d  = 1'b1;
              resp_status_d = ST_OK;
              resp_count_d  = '0;
            end else begin
              state_d = S_SCAN;
            end
          end else begin
            state_d = S_CMP;
          end
        end
      end

      S_CMP: begin
        case (op_q)
          OP_INSERT: begin
            if (hit_c[0])                    err_d = ST_EXIST;
            else if (count_q == CW'(DEPTH))  err_d = ST_FULL;
            else                             err_d = ST_OK;
          end
          OP_DELETE: err_d = hit_c[0] ? ST_OK : ST_ABSENT;
          OP_CLEAR:  err_d = ST_OK;
          default:   err_d = ST_ABSENT;
        endcase
        for (int m = 0; m < NUM_METRICS; m++) begin
          pos_d[m] = (op_q == OP_DELETE) ? hit_pos_c[m] : ins_pos_c[m];
        end
        state_d = S_COMMIT;
      end

      S_COMMIT: begin
        if (err_q == ST_OK) begin
          case (op_q)
            OP_INSERT: begin
              for (int m = 0; m < NUM_METRICS; m++) begin
                for (int i = 1; i < DEPTH; i++) begin
                  if (CW'(i) > pos_q[m]) begin
                    val_d[METRIC_LOG'(m)][DEPTH_LOG'(i)] = val_q[METRIC_LOG'(m)][DEPTH_LOG'(i-1)];
                    id_d[METRIC_LOG'(m)][DEPTH_LOG'(i)]  = id_q[METRIC_LOG'(m)][DEPTH_LOG'(i-1)];
                  end
                end
                val_d[METRIC_LOG'(m)][pos_q[m][DEPTH_LOG-1:0]] = rmet_q[m*VAL_W +: VAL_W];
                id_d[METRIC_LOG'(m)][pos_q[m][DEPTH_LOG-1:0]]  = rid_q;
              end
              count_d = count_q + CW'(1);
            end
            OP_DELETE: begin
              for (int m = 0; m < NUM_METRICS; m++) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                  if (CW'(i) >= pos_q[m]) begin
                    val_d[METRIC_LOG'(m)][DEPTH_LOG'(i)] = val_q[METRIC_LOG'(m)][DEPTH_LOG'(i+1)];
                    id_d[METRIC_LOG'(m)][DEPTH_LOG'(i)]  = id_q[METRIC_LOG'(m)][DEPTH_LOG'(i+1)];
                  end
                end
              end
              count_d = count_q - CW'(1);
            end
            OP_CLEAR: count_d = '0;
            default: ;
          endcase
        end
        resp_valid_d  = 1'b1;
        resp_status_d = err_q;
        resp_count_d  = count_d;
        state_d       = S_DONE;
      end

      S_SCAN: begin
        if (out_valid_q) begin
          // Hold the presented entry until the consumer takes it
          if (out_ready) begin
            out_valid_d = 1'b0;
            emitted_d   = emitted_q + CW'(1);
            idx_d       = idx_q + CW'(1);
          end
        end else if ((idx_q == count_q) ||
                     ((limit_q != '0) && (emitted_q == limit_q))) begin
          resp_valid_d  = 1'b1;
          resp_status_d = ST_OK;
          resp_count_d  = emitted_q;
          state_d       = S_DONE;
        end else if ((op_q == OP_READ_A) ||
                     mask_q[id_q[sel_q][idx_q[DEPTH_LOG-1:0]]]) begin
          out_valid_d = 1'b1;
          out_val_d   = val_q[sel_q][idx_q[DEPTH_LOG-1:0]];
          out_id_d    = id_q[sel_q][idx_q[DEPTH_LOG-1:0]];
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_IDLE);
  end

  // Control and output registers; reset abandons any operation and empties the table
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      req_ready_q   <= 1'b1;
      count_q       <= '0;
      idx_q         <= '0;
      emitted_q     <= '0;
      out_valid_q   <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_status_q <= '0;
      resp_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      count_q       <= count_d;
      idx_q         <= idx_d;
      emitted_q     <= emitted_d;
      out_valid_q   <= out_valid_d;
      resp_valid_q  <= resp_valid_d;
      resp_status_q <= resp_status_d;
      resp_count_q  <= resp_count_d;
    end
  end

  // Request capture, list storage and stream data; contents above count are don't-care
  always_ff @(posedge clk) begin
    op_q      <= op_d;
    rid_q     <= rid_d;
    rmet_q    <= rmet_d;
    mask_q    <= mask_d;
    sel_q     <= sel_d;
    limit_q   <= limit_d;
    pos_q     <= pos_d;
    err_q     <= err_d;
    val_q     <= val_d;
    id_q      <= id_d;
    out_val_q <= out_val_d;
    out_id_q  <= out_id_d;
  end

  assign req_ready   = req_ready_q;
  assign out_valid   = out_valid_q;
  assign out_val     = out_val_q;
  assign out_id      = out_id_q;
  assign resp_valid  = resp_valid_q;
  assign resp_status = resp_status_q;
  assign resp_count  = resp_count_q;
  assign count       = count_q;

endmodule

// File: tb/tb_sorted_metric_table.sv
// Bench for sorted_metric_table: insertion-ordered entry model, stable-sort reads.
module tb_sorted_metric_table;

  localparam int DEPTH = 256;

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_op;
  logic [7:0]   req_id;
  logic [63:0]  req_metrics;
  logic [255:0] req_mask;
  logic [2:0]   req_sel;
  logic [8:0]   req_limit;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_val;
  logic [7:0]   out_id;
  logic         resp_valid;
  logic [1:0]   resp_status;
  logic [8:0]   resp_count;
  logic [8:0]   count;

  sorted_metric_table dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_id(req_id), .req_metrics(req_metrics),
    .req_mask(req_mask), .req_sel(req_sel), .req_limit(req_limit),
    .out_valid(out_valid), .out_ready(out_ready), .out_val(out_val),
    .out_id(out_id), .resp_valid(resp_valid), .resp_status(resp_status),
    .resp_count(resp_count), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [63:0] met;
  } ent_t;

  ent_t tbl[$];          // live entries in insertion order
  int   exp_val[$];
  int   exp_id[$];
  int   got_val[$];
  int   got_id[$];
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;
  bit   resp_pending = 1'b0;
  int   exp_status;
  int   exp_rcount;
  int   rdy_mode = 0;    // 0 always ready, 1 random, 2 stalled
  bit   prev_hold = 1'b0;
  logic [7:0] hold_val;
  logic [7:0] hold_id;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end else begin
      passes++;
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    fails++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic int find_id(input int id);
    foreach (tbl[k]) if (tbl[k].id == id) return k;
    return -1;
  endfunction

  // Expected stream: entries ordered by (metric value, insertion order), filtered, limited
  task automatic model_read(input int op, input int sel, input logic [255:0] mask,
                            input int lim, output int emitted);
    longint keys[$];
    int id;
    int v;
    keys = {};
    foreach (tbl[k]) begin
      v = int'(tbl[k].met[sel*8 +: 8]);
      keys.push_back((longint'(v) << 32) | (longint'(k) << 16) | longint'(tbl[k].id));
    end
    keys.sort();
    emitted = 0;
    foreach (keys[j]) begin
      if (lim != 0 && emitted == lim) break;
      id = int'(keys[j] & 64'hffff);
      v  = int'(keys[j] >>> 32);
      if (op == 3 || mask[id]) begin
        exp_val.push_back(v);
        exp_id.push_back(id);
        emitted++;
      end
    end
  endtask

  // Consumer-ready driver
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Compare process: stream transfers, stall stability and completion responses
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (out_valid && prev_hold) begin
        chk("hold_val", 64'(out_val), 64'(hold_val));
        chk("hold_id", 64'(out_id), 64'(hold_id));
      end
      prev_hold = out_valid && !out_ready;
      hold_val  = out_val;
      hold_id   = out_id;
      if (out_valid && out_ready) begin
        got_val.push_back(int'(out_val));
        got_id.push_back(int'(out_id));
        if (exp_val.size() == 0) begin
          fail_now("unexpected_out");
        end else begin
          chk("out_val", 64'(out_val), 64'(exp_val.pop_front()));
          chk("out_id", 64'(out_id), 64'(exp_id.pop_front()));
        end
      end
      if (resp_valid) begin
        if (!resp_pending) begin
          fail_now("spurious_resp_valid");
        end else begin
          chk("resp_status", 64'(resp_status), 64'(exp_status));
          chk("resp_count", 64'(resp_count), 64'(exp_rcount));
          chk("stream_remaining", 64'(exp_val.size()), 64'd0);
          exp_val.delete();
          exp_id.delete();
          resp_pending = 1'b0;
        end
      end
    end
  end

  task automatic scramble_inputs();
    req_op      = 3'($urandom);
    req_id      = 8'($urandom);
    req_metrics = {$urandom, $urandom};
    req_sel     = 3'($urandom);
    req_limit   = 9'($urandom);
    for (int w = 0; w < 8; w++) req_mask[w*32 +: 32] = $urandom;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_op(input logic [2:0] op, input logic [7:0] id, input logic [63:0] met,
                       input logic [255:0] mask, input logic [2:0] sel, input logic [8:0] lim);
    int n;
    int k;
    int em;
    ent_t e;
    wait_ready();
    if (!req_ready) begin
      chk("req_ready_wait", 64'(req_ready), 64'd1);
      return;
    end
    exp_status = 0;
    case (op)
      3'd0: begin
        k = find_id(int'(id));
        if (k >= 0) exp_status = 2;
        else if (tbl.size() == DEPTH) exp_status = 1;
        else begin
          e.id = int'(id);
          e.met = met;
          tbl.push_back(e);
        end
        exp_rcount = tbl.size();
      end
      3'd1: begin
        k = find_id(int'(id));
        if (k < 0) exp_status = 3;
        else tbl.delete(k);
        exp_rcount = tbl.size();
      end
      3'd2, 3'd3: begin
        model_read(int'(op), int'(sel), mask, int'(lim), em);
        exp_rcount = em;
      end
      3'd4: begin
        tbl.delete();
        exp_rcount = 0;
      end
      default: begin
        exp_status = 3;
        exp_rcount = tbl.size();
      end
    endcase
    resp_pending = 1'b1;
    req_valid    = 1'b1;
    req_op       = op;
    req_id       = id;
    req_metrics  = met;
    req_mask     = mask;
    req_sel      = sel;
    req_limit    = lim;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    scramble_inputs();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 4000);
    if (!resp_valid) begin
      fail_now("resp_timeout");
      resp_pending = 1'b0;
      exp_val.delete();
      exp_id.delete();
    end else begin
      if (op != 3'd2 && op != 3'd3) chk("latency", 64'(n), 64'd3);
      chk("count", 64'(count), 64'(tbl.size()));
    end
  endtask

  task automatic raw_req(input logic [2:0] op, input logic [7:0] id);
    wait_ready();
    req_valid   = 1'b1;
    req_op      = op;
    req_id      = id;
    req_metrics = {8{8'h11}};
    req_sel     = 3'd0;
    req_limit   = 9'd0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic pulse_reset_and_check(input string tag);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    rdy_mode = 0;
    tbl.delete();
    @(negedge clk);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    chk({tag, "_count"}, 64'(count), 64'd0);
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    repeat (6) @(negedge clk);
  endtask

  task automatic bp_test();
    logic [255:0] z;
    z = '0;
    rdy_mode = 2;
    fork
      do_op(3'd3, 8'd0, 64'd0, z, 3'd1, 9'd0);
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        chk("bp_valid_seen", 64'(out_valid), 64'd1);
        repeat (5) begin
          @(negedge clk);
          chk("bp_valid_held", 64'(out_valid), 64'd1);
          chk("bp_req_ready", 64'(req_ready), 64'd0);
        end
        rdy_mode = 0;
      end
    join
  endtask

  logic [255:0] mask_v;
  logic [63:0]  met_v;

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    scramble_inputs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_status", 64'(resp_status), 64'd0);
    chk("rst_resp_count", 64'(resp_count), 64'd0);

    // Stable ordering of equal values
    mask_v = '0;
    do_op(3'd0, 8'd5, {8{8'h40}}, mask_v, 3'd0, 9'd0);
    do_op(3'd0, 8'd9, {8{8'h20}}, mask_v, 3'd0, 9'd0);
    do_op(3'd0, 8'd2, {8{8'h40}}, mask_v, 3'd0, 9'd0);
    got_val.delete(); got_id.delete();
    do_op(3'd3, 8'd0, 64'd0, mask_v, 3'd0, 9'd0);
    chk("lit1_n", 64'(got_val.size()), 64'd3);
    chk("lit1_v0", 64'(got_val[0]), 64'h20); chk("lit1_i0", 64'(got_id[0]), 64'd9);
    chk("lit1_v1", 64'(got_val[1]), 64'h40); chk("lit1_i1", 64'(got_id[1]), 64'd5);
    chk("lit1_v2", 64'(got_val[2]), 64'h40); chk("lit1_i2", 64'(got_id[2]), 64'd2);

    do_op(3'd0, 8'd9, {8{8'h77}}, mask_v, 3'd0, 9'd0);   // duplicate id
    chk("dup_status", 64'(resp_status), 64'd2);
    do_op(3'd1, 8'd5, 64'd0, mask_v, 3'd0, 9'd0);
    chk("del5_count", 64'(count), 64'd2);
    got_val.delete(); got_id.delete();
    do_op(3'd3, 8'd0, 64'd0, mask_v, 3'd3, 9'd0);
    chk("lit2_n", 64'(got_val.size()), 64'd2);
    chk("lit2_v0", 64'(got_val[0]), 64'h20); chk("lit2_i0", 64'(got_id[0]), 64'd9);
    chk("lit2_v1", 64'(got_val[1]), 64'h40); chk("lit2_i1", 64'(got_id[1]), 64'd2);
    do_op(3'd1, 8'd5, 64'd0, mask_v, 3'd0, 9'd0);        // absent
    chk("absent_status", 64'(resp_status), 64'd3);

    do_op(3'd0, 8'd5, {8{8'h40}}, mask_v, 3'd0, 9'd0);
    mask_v = '0;
    mask_v[2] = 1'b1;
    got_val.delete(); got_id.delete();
    do_op(3'd2, 8'd0, 64'd0, mask_v, 3'd0, 9'd0);
    chk("lit3_n", 64'(got_val.size()), 64'd1);
    chk("lit3_v0", 64'(got_val[0]), 64'h40); chk("lit3_i0", 64'(got_id[0]), 64'd2);
    chk("lit3_rc", 64'(resp_count), 64'd1);
    got_val.delete(); got_id.delete();
    do_op(3'd3, 8'd0, 64'd0, mask_v, 3'd0, 9'd2);
    chk("lit4_rc", 64'(resp_count), 64'd2);
    chk("lit4_i1", 64'(got_id[1]), 64'd2);

    bp_test();
    do_op(3'd6, 8'd0, 64'd0, mask_v, 3'd0, 9'd0);        // illegal op
    chk("illegal_status", 64'(resp_status), 64'd3);

    // Reset while streaming, then while committing
    rdy_mode = 2;
    raw_req(3'd3, 8'd0);
    repeat (3) @(negedge clk);
    chk("scan_out_valid", 64'(out_valid), 64'd1);
    pulse_reset_and_check("rst_scan");
    do_op(3'd0, 8'd40, {8{8'h05}}, mask_v, 3'd0, 9'd0);
    raw_req(3'd0, 8'd77);
    pulse_reset_and_check("rst_commit");
    do_op(3'd3, 8'd0, 64'd0, mask_v, 3'd0, 9'd0);
    chk("empty_read_rc", 64'(resp_count), 64'd0);

    // Randomised traffic with ties, filters, limits and back-pressure
    rdy_mode = 1;
    for (int t = 0; t < 200; t++) begin
      int r;
      logic [2:0] op;
      r = int'($urandom_range(9));
      case (r)
        0, 1, 2, 3: op = 3'd0;
        4, 5:       op = 3'd1;
        6:          op = 3'd2;
        7:          op = 3'd3;
        8:          op = 3'(5 + $urandom_range(2));
        default:    op = ($urandom_range(3) == 0) ? 3'd4 : 3'd0;
      endcase
      for (int m = 0; m < 8; m++) met_v[m*8 +: 8] = 8'($urandom_range(7) << 5);
      for (int w = 0; w < 8; w++) mask_v[w*32 +: 32] = $urandom;
      do_op(op, 8'($urandom_range(31)), met_v, mask_v, 3'($urandom),
            ($urandom_range(3) == 0) ? 9'd0 : 9'($urandom_range(6)));
    end

    // Full table boundary
    rdy_mode = 0;
    do_op(3'd4, 8'd0, 64'd0, mask_v, 3'd0, 9'd0);
    for (int i = 0; i < DEPTH; i++) begin
      met_v = {$urandom, $urandom};
      do_op(3'd0, 8'(i), met_v, mask_v, 3'd0, 9'd0);
    end
    chk("full_count", 64'(count), 64'd256);
    do_op(3'd0, 8'd100, 64'd0, mask_v, 3'd0, 9'd0);
    chk("full_dup_status", 64'(resp_status), 64'd2);
    do_op(3'd1, 8'd7, 64'd0, mask_v, 3'd0, 9'd0);
    do_op(3'd1, 8'd7, 64'd0, mask_v, 3'd0, 9'd0);
    chk("full_absent_count", 64'(count), 64'd255);
    do_op(3'd0, 8'd7, {8{8'hff}}, mask_v, 3'd0, 9'd0);
    rdy_mode = 1;
    do_op(3'd3, 8'd0, 64'd0, mask_v, 3'($urandom), 9'd0);
    do_op(3'd2, 8'd0, 64'd0, mask_v, 3'($urandom), 9'd10);
    do_op(3'd3, 8'd0, 64'd0, mask_v, 3'd7, 9'd256);

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
